demux_stream: RTL and testbench
===============================

# demux_stream

Parametrised 1-to-N streaming demultiplexer with a registered, handshaked output stage per channel. It sits between a single producer and N independent consumers, steering each accepted beat to the channel named by a select input or, optionally, to channels in round-robin order. It also flags out-of-range selects.

## Interface
- DATA_W, 8: payload width in bits.
- N_OUT, 4: output channel count, 2..16.
- SEL_W, $clog2(N_OUT): select width, derived, never overridden.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  input payload.
- in_valid  in  1  input beat present.
- in_sel  in  SEL_W  destination channel for the current beat.
- in_ready  out  1  block can accept the current beat.
- seq_mode  in  1  1 = round-robin distribution, ignore in_sel (only with macro).
- out_data  out  N_OUT*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W].
- out_valid  out  N_OUT  channel k holds an unconsumed beat.
- out_ready  in  N_OUT  consumer k accepts its beat.
- sel_err  out  1  one-cycle pulse: beat with in_sel >= N_OUT was dropped.

## Operation
- Each channel owns a one-entry holding register (valid bit plus data).
- Target channel t = in_sel, or rr_ptr when seq_mode=1 (macro builds only).
- in_ready = !out_valid[t] || out_ready[t] when t < N_OUT; in_ready = 1 when t >= N_OUT.
- Accept (in_valid && in_ready, t < N_OUT): register data into channel t and set out_valid[t].
- Channel k drain (out_valid[k] && out_ready[k]): clear out_valid[k] unless refilled in the same cycle.
- Simultaneous drain and refill of the same channel: out_valid stays 1 and data is replaced. This gives full throughput.
- Non-target channels drain independently and never stall on other channels.
- out_data[k] holds its last value after consumption. It is never forced to zero.
- Out-of-range select with in_valid: beat consumed (in_ready=1), nothing written, sel_err=1 next cycle.
- in_sel and seq_mode are sampled only in cycles with in_valid=1.

## Timing
- Reset values: out_valid=0, out_data=0, sel_err=0, rr_ptr=0. in_ready follows combinationally from the reset state, so it is 1.
- Latency: a beat accepted at edge n is visible on out_valid/out_data after edge n, for one cycle minimum.
- in_ready is combinational from in_sel, seq_mode, out_valid, out_ready. There is no combinational path from in_data to any output.
- sel_err is registered: high for exactly the cycle after the dropped beat.
- Reset asserted mid-transfer: all held beats are discarded immediately and rr_ptr returns to 0.

## Configuration
- DEMUX_STREAM_RR_EN defined: builds rr_ptr (SEL_W-bit counter).
  - When seq_mode=1, t = rr_ptr. rr_ptr advances by 1 on each accepted beat and wraps from N_OUT-1 to 0.
  - rr_ptr holds while the target is stalled.
  - In seq_mode, sel_err never fires.
- DEMUX_STREAM_RR_EN undefined: seq_mode port exists but is ignored, no counter is built, and t = in_sel always.

## Structure
- Shared package demux_pkg: DEMUX_MAX_OUT=16 and the function computing SEL_W.
- Sub-module demux_slot: one channel holding register with load/drain handshake. It is instantiated N_OUT times in a generate loop.
- Top level contains target selection, in_ready mux, rr_ptr, and sel_err.

## Test plan
- Reset, then in_sel=2, in_data=8'hA5, in_valid=1 for one cycle, all out_ready=0 -> after the next edge, out_valid=4'b0100 and channel 2 data=A5. Other channels stay 0.
- Channel 1 full, out_ready[1]=0, in_sel=1 -> in_ready=0. Raise out_ready[1] with new beat 8'h3C -> same-cycle drain and refill, out_valid[1] stays 1, data=3C.
- Channel 0 stalled and full, then beats to channel 3 -> accepted each cycle. Channel 0 is unaffected.
- N_OUT=3, in_sel=3, in_valid=1 -> in_ready=1, no out_valid change, sel_err=1 for exactly one cycle.
- With DEMUX_STREAM_RR_EN, seq_mode=1, six consecutive beats 0..5, all out_ready=1 -> channels receive 0,1,2,3,0,1. Stalling channel 2 holds rr_ptr at 2.
- Assert rst while channels 0 and 3 are valid -> out_valid=0 and out_data=0 immediately (asynchronous), rr_ptr=0 after release.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the demux_stream block: channel-count limit and the
// helper that derives the select width from the channel count.
package demux_pkg;

  localparam int DEMUX_MAX_OUT = 16;

  // Width of a select that can name every one of n_out channels (at least 1 bit).
  function automatic int sel_width(input int n_out);
    return (n_out <= 2) ? 1 : $clog2(n_out);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel of demux_stream: a single-entry holding register with a
// valid/ready drain side and a load strobe from the steering logic.
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Hold one beat; a load in the same cycle as a drain keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      // NOTE: the payload register is reset too, so out_data reads 0 after reset rather than X.
      data  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every slot samples pre-edge values.
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_stream.sv
// 1-to-N streaming demultiplexer. Each accepted beat is steered to the channel
// named by in_sel; out-of-range selects are swallowed and flagged on sel_err.
// Optional round-robin steering (seq_mode) is built when DEMUX_STREAM_RR_EN is
// defined; otherwise seq_mode is ignored and no pointer is built.
module demux_stream
  import demux_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_OUT  = 4,
  localparam int SEL_W  = sel_width(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic [SEL_W-1:0]        in_sel,
  output logic                    in_ready,
  input  logic                    seq_mode,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    sel_err
);

  logic [SEL_W-1:0] tgt;
  logic             tgt_ok;
  logic             tgt_busy;
  logic             accept;

`ifdef DEMUX_STREAM_RR_EN
  logic [SEL_W-1:0] rr_ptr;

  assign tgt = seq_mode ? rr_ptr : in_sel;

  // Round-robin pointer: advances only on beats actually accepted in seq_mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && seq_mode) begin
      rr_ptr <= (rr_ptr == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end
`else
  logic unused_seq_mode;

  assign unused_seq_mode = seq_mode;
  assign tgt             = in_sel;
`endif

  // Selects beyond the last channel are legal inputs that get dropped.
  assign tgt_ok = (int'(tgt) < N_OUT);

  // Ready mux: the target stalls only when it is full and not draining this cycle.
  always_comb begin
    // NOTE: defaulting before the loop keeps this purely combinational (no latch).
    tgt_busy = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (tgt == SEL_W'(k)) tgt_busy = out_valid[k] && !out_ready[k];
    end
    in_ready = !tgt_ok || !tgt_busy;
  end

  assign accept = in_valid && in_ready && tgt_ok;

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (accept && (tgt == SEL_W'(g))),
      .load_data (in_data),
      .ready     (out_ready[g]),
      .valid     (out_valid[g]),
      .data      (out_data[g*DATA_W +: DATA_W])
    );
  end

  // Registered drop flag: one-cycle pulse after a beat with an out-of-range select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= in_valid && !tgt_ok;
    end
  end

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: scoreboard queues per channel filled by
// the stimulus and drained by an independent monitor on consumed beats, plus
// direct checks of ready, valid, reset and sel_err behaviour.
module tb_demux_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  // Main instance: 4 channels
  logic [7:0]  in_data  = '0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_sel   = '0;
  logic        in_ready;
  logic        seq_mode = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic        sel_err;

  // Second instance: 3 channels, so select value 3 is out of range
  logic [7:0]  in_data3  = '0;
  logic        in_valid3 = 1'b0;
  logic [1:0]  in_sel3   = '0;
  logic        in_ready3;
  logic [23:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3 = '0;
  logic        sel_err3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q [4][$];

  demux_stream #(.DATA_W(8), .N_OUT(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_sel(in_sel), .in_ready(in_ready), .seq_mode(seq_mode),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err)
  );

  demux_stream #(.DATA_W(8), .N_OUT(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
    .in_sel(in_sel3), .in_ready(in_ready3), .seq_mode(1'b0),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .sel_err(sel_err3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a beat and check the combinational ready; push the expected beat if accepted.
  task automatic offer(input logic [1:0] sel, input logic [7:0] d, input logic exp_rdy,
                       input int exp_ch, input string name);
    in_sel   = sel;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    check(name, in_ready, exp_rdy);
    if (exp_rdy && exp_ch >= 0) exp_q[exp_ch].push_back(d);
  endtask

  // Monitor: every consumed beat must match the head of its channel queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 4; k++) begin
          if (out_valid[k] && out_ready[k]) begin
            if (exp_q[k].size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL sb_ch%0d: got unexpected beat %0h, expected none", k, out_data[k*8 +: 8]);
            end else begin
              check($sformatf("sb_ch%0d", k), 64'(out_data[k*8 +: 8]), 64'(exp_q[k].pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 4'b0000);
    check("rst_out_data", out_data, 32'h0);
    check("rst_sel_err", sel_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    tick;
    rst = 1'b0;

    // Single beat to channel 2, then drain it
    offer(2'd2, 8'hA5, 1'b1, 2, "a_in_ready");
    tick;
    in_valid = 1'b0;
    check("a_out_valid", out_valid, 4'b0100);
    check("a_ch2_data", out_data[23:16], 8'hA5);
    check("a_other_data", out_data & 32'hFF00_FFFF, 32'h0);
    out_ready = 4'b0100;
    tick;
    out_ready = 4'b0000;
    check("a_drained", out_valid, 4'b0000);
    check("a_data_held", out_data[23:16], 8'hA5);

    // Channel 1 full and stalled, then simultaneous drain and refill
    offer(2'd1, 8'h11, 1'b1, 1, "b_first_ready");
    tick;
    offer(2'd1, 8'h3C, 1'b0, -1, "b_stalled_ready");
    tick;
    check("b_still_one", out_data[15:8], 8'h11);
    out_ready = 4'b0010;
    #1;
    check("b_refill_ready", in_ready, 1'b1);
    exp_q[1].push_back(8'h3C);
    tick;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    check("b_valid_kept", out_valid, 4'b0010);
    check("b_ch1_data", out_data[15:8], 8'h3C);
    out_ready = 4'b0010;
    tick;
    out_ready = 4'b0000;
    check("b_empty", out_valid, 4'b0000);

    // Channel 0 stalled; channel 3 keeps full throughput
    offer(2'd0, 8'h77, 1'b1, 0, "c_ch0_ready");
    tick;
    out_ready = 4'b1000;
    for (int i = 1; i <= 3; i++) begin
      offer(2'd3, 8'(i), 1'b1, 3, $sformatf("c_ch3_ready%0d", i));
      tick;
    end
    in_valid = 1'b0;
    tick;
    check("c_only_ch0", out_valid, 4'b0001);
    check("c_ch0_data", out_data[7:0], 8'h77);
    out_ready = 4'b0001;
    tick;
    out_ready = 4'b0000;
    check("c_empty", out_valid, 4'b0000);
    check("c_no_sel_err", sel_err, 1'b0);

    // Out-of-range select on the 3-channel instance
    in_sel3   = 2'd3;
    in_data3  = 8'hEE;
    in_valid3 = 1'b1;
    #1;
    check("d_in_ready", in_ready3, 1'b1);
    check("d_err_before", sel_err3, 1'b0);
    tick;
    in_valid3 = 1'b0;
    check("d_sel_err", sel_err3, 1'b1);
    check("d_no_valid", out_valid3, 3'b000);
    check("d_no_data", out_data3, 24'h0);
    tick;
    check("d_err_pulse", sel_err3, 1'b0);
    in_sel3   = 2'd2;
    in_data3  = 8'h5D;
    in_valid3 = 1'b1;
    tick;
    in_valid3 = 1'b0;
    check("d_inrange_err", sel_err3, 1'b0);
    check("d_inrange_valid", out_valid3, 3'b100);
    check("d_inrange_data", out_data3[23:16], 8'h5D);

`ifdef DEMUX_STREAM_RR_EN
    // Round-robin: six beats with all channels ready
    seq_mode  = 1'b1;
    out_ready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      offer(2'd0, 8'(i), 1'b1, i % 4, $sformatf("rr_ready%0d", i));
      tick;
    end
    in_valid = 1'b0;
    tick;
    // Pointer is at 2; stall channel 2 and go round once
    out_ready = 4'b1011;
    offer(2'd0, 8'h10, 1'b1, 2, "rr_s0");
    tick;
    offer(2'd0, 8'h11, 1'b1, 3, "rr_s1");
    tick;
    offer(2'd0, 8'h12, 1'b1, 0, "rr_s2");
    tick;
    offer(2'd0, 8'h13, 1'b1, 1, "rr_s3");
    tick;
    offer(2'd1, 8'h14, 1'b0, -1, "rr_stall_a");
    tick;
    #1;
    check("rr_stall_b", in_ready, 1'b0);
    out_ready = 4'b1111;
    #1;
    check("rr_release", in_ready, 1'b1);
    exp_q[2].push_back(8'h14);
    tick;
    in_valid = 1'b0;
    tick;
    out_ready = 4'b0000;
    offer(2'd0, 8'h15, 1'b1, 3, "rr_next");
    tick;
    in_valid = 1'b0;
    check("rr_next_valid", out_valid, 4'b1000);
    check("rr_next_data", out_data[31:24], 8'h15);
    check("rr_no_err", sel_err, 1'b0);
    out_ready = 4'b1111;
    offer(2'd3, 8'h16, 1'b1, 0, "rr_to_ch0");
    tick;
    in_valid = 1'b0;
    tick;
    out_ready = 4'b0000;
    seq_mode  = 1'b0;
`endif

    // Asynchronous reset with channels 0 and 3 holding beats
    offer(2'd0, 8'h5A, 1'b1, -1, "r_load0");
    tick;
    offer(2'd3, 8'h99, 1'b1, -1, "r_load3");
    tick;
    in_valid = 1'b0;
    check("r_pre_valid", out_valid, 4'b1001);
    #2 rst = 1'b1;
    #1;
    check("r_async_valid", out_valid, 4'b0000);
    check("r_async_data", out_data, 32'h0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    tick;
    rst = 1'b0;

`ifdef DEMUX_STREAM_RR_EN
    // Pointer restarts at channel 0
    seq_mode = 1'b1;
    offer(2'd2, 8'h42, 1'b1, -1, "r_rr_ready");
    tick;
    in_valid = 1'b0;
    seq_mode = 1'b0;
    check("r_rr_ch0", out_valid, 4'b0001);
    check("r_rr_data", out_data[7:0], 8'h42);
`endif

    for (int k = 0; k < 4; k++) check($sformatf("sb_left_ch%0d", k), exp_q[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
